inst_encoder: RTL and testbench
===============================

# inst_encoder

- Sequential RISC-V RV32I instruction encoder: the inverse of the core's immediate/field decode path.
- Accepts decoded fields (opcode, register indices, funct3/funct7, architectural immediate) over a valid/ready handshake and scatters them into a 32-bit instruction word.
- Holds each word in a backpressured output register tagged with a sequential instruction-memory word address.
- Sits between the test/boot program builder and the instruction-memory write port.

## Interface
- DEPTH, 64: instruction-memory depth in words; address counter wraps after DEPTH words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; combinational, = !out_valid || out_ready.
- in_opcode  in  7  RV32I opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3 / in_funct7  in  7  function fields.
- in_imm  in  32  architectural immediate: byte offset for branch/JAL; full value with low 12 bits zero for LUI/AUIPC.
- out_valid  out  1  out_inst/out_addr/out_err valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_addr  out  32  byte address of out_inst.
- out_last  out  1  out_addr is word DEPTH-1.
- out_err  out  1  field/range error on this word.
- err_count  out  8  saturating error counter.

## Operation
- Format by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - any other opcode → I layout.
- Layouts:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - I-shift (op 0010011, f3 001/101): funct7|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Fields not used by a format are ignored.
- Imm bits outside the encoded range are truncated unless checking is enabled (see Configuration).
- State: out register (valid, inst, addr, err, last); word pointer ptr (0..DEPTH-1); err_count.
- Accept = in_valid && in_ready. On accept:
  - out register ← encoded word;
  - out_addr ← BASE_ADDR + 4*ptr; out_last ← (ptr == DEPTH-1);
  - ptr ← (ptr == DEPTH-1) ? 0 : ptr+1.
- Output handshake: out_valid && out_ready.
  - Handshake with no accept in the same cycle: out_valid ← 0.
  - Handshake and accept in the same cycle: the register reloads with the new word and out_valid stays 1.
- While out_valid && !out_ready: in_ready = 0; all out_* held stable.
- Reset values: out_valid 0, out_inst 0, out_addr BASE_ADDR, out_last 0, out_err 0, err_count 0, ptr 0.
- Reset mid-stall discards the held word.

## Timing
- Latency 1: fields accepted at edge N appear on out_* after edge N.
- Throughput: 1 word/cycle while out_ready is held high.
- in_ready is the only combinational input→output path; it depends on out_ready.
- err_count updates on the same edge that loads the errored word.
- Saturates at 255; does not wrap.
- ptr wrap is seamless; the word after address BASE_ADDR+4*(DEPTH-1) is at BASE_ADDR.

## Configuration
- IMM_RANGE_CHECK_EN defined: out_err = 1 when any of these holds:
  - I (non-shift) or S: imm not signed-12 (imm[31:11] not all equal);
  - I-shift: imm[31:5] ≠ 0;
  - B: imm not signed-13 or imm[0] = 1;
  - J: imm not signed-21 or imm[0] = 1;
  - U: imm[11:0] ≠ 0;
  - opcode not in the list above.
- Errored words:
  - out_inst forced to 32'h0000_0013 (NOP);
  - still consume an address;
  - increment err_count.
- Not defined: out_err tied 0, err_count tied 0, no substitution; out-of-range bits truncated.

## Test plan
- ADDI: op 0010011, rd 1, rs1 0, f3 0, imm 5 → out_inst 0x0050_0093, out_addr BASE_ADDR, out_valid 1 one cycle after accept.
- SW: op 0100011, rs1 1, rs2 2, f3 010, imm 8 → 0x0020_A423.
- BEQ: op 1100011, rs1 1, rs2 2, f3 0, imm 0xFFFF_FFFC → 0xFE20_8EE3. JAL: rd 1, imm 0x800 → 0x0010_00EF.
- Macro defined: ADDI imm 2048 → out_err 1, out_inst 0x0000_0013, err_count 1. Same stimulus without the macro → out_err 0, out_inst 0x8000_0093.
- DEPTH=4, five back-to-back ADDIs:
  - out_ready low for 3 cycles after the first word → in_ready 0 and out_* stable during the stall;
  - out_addr sequence 0, 4, 8, 12, 0;
  - out_last 1 only on 12.
- rst asserted while out_valid=1 and stalled → next cycle out_valid 0, err_count 0; next accepted word gets out_addr BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: scatters decoded fields into a 32-bit word and
// presents it with a sequential imem address. Optional: IMM_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_last,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } enc_req_t;

  enc_req_t      w_req;
  fmt_e          w_fmt;
  logic [31:0]   w_enc;
  logic [31:0]   w_word;
  logic [31:0]   w_word_addr;
  logic          w_accept;
  logic          w_ptr_last;

  logic          r_out_valid;
  logic [31:0]   r_inst;
  logic [31:0]   r_addr;
  logic          r_last;
  logic [PW-1:0] r_ptr;

  assign w_req = '{op: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   f3: in_funct3, f7: in_funct7, imm: in_imm};

  // Backpressure: a held word blocks new input until the consumer takes it.
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_ptr_last  = (r_ptr == LAST_PTR);
  assign w_word_addr = BASE_ADDR + (32'(r_ptr) << 2);

  always_comb begin
    w_fmt = FMT_I;
    unique case (w_req.op)
      OP_REG:                              w_fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: w_fmt = FMT_I;
      OP_STORE:                            w_fmt = FMT_S;
      OP_BRANCH:                           w_fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    w_fmt = FMT_U;
      OP_JAL:                              w_fmt = FMT_J;
      default:                             w_fmt = FMT_I;
    endcase
    // SLLI/SRLI/SRAI carry funct7 in the upper immediate field.
    if (w_req.op == OP_IMM && (w_req.f3 == 3'b001 || w_req.f3 == 3'b101))
      w_fmt = FMT_ISH;
  end

  always_comb begin
    w_enc = '0;
    unique case (w_fmt)
      FMT_R:   w_enc = {w_req.f7, w_req.rs2, w_req.rs1, w_req.f3, w_req.rd, w_req.op};
      FMT_ISH: w_enc = {w_req.f7, w_req.imm[4:0], w_req.rs1, w_req.f3, w_req.rd, w_req.op};
      FMT_S:   w_enc = {w_req.imm[11:5], w_req.rs2, w_req.rs1, w_req.f3,
                        w_req.imm[4:0], w_req.op};
      FMT_B:   w_enc = {w_req.imm[12], w_req.imm[10:5], w_req.rs2, w_req.rs1, w_req.f3,
                        w_req.imm[4:1], w_req.imm[11], w_req.op};
      FMT_U:   w_enc = {w_req.imm[31:12], w_req.rd, w_req.op};
      FMT_J:   w_enc = {w_req.imm[20], w_req.imm[10:1], w_req.imm[11],
                        w_req.imm[19:12], w_req.rd, w_req.op};
      default: w_enc = {w_req.imm[11:0], w_req.rs1, w_req.f3, w_req.rd, w_req.op};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic       w_known;
  logic       w_range_err;
  logic       w_err;
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_comb begin
    w_known = 1'b0;
    unique case (w_req.op)
      OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: w_known = 1'b1;
      default:                             w_known = 1'b0;
    endcase
  end

  // Sign-extension check: every bit above the field's sign bit must match it.
  always_comb begin
    w_range_err = 1'b0;
    unique case (w_fmt)
      FMT_I, FMT_S: w_range_err = !((&w_req.imm[31:11]) || !(|w_req.imm[31:11]));
      FMT_ISH:      w_range_err = |w_req.imm[31:5];
      FMT_B:        w_range_err = !((&w_req.imm[31:12]) || !(|w_req.imm[31:12]))
                                  || w_req.imm[0];
      FMT_J:        w_range_err = !((&w_req.imm[31:20]) || !(|w_req.imm[31:20]))
                                  || w_req.imm[0];
      FMT_U:        w_range_err = |w_req.imm[11:0];
      default:      w_range_err = 1'b0;
    endcase
  end

  assign w_err  = w_range_err || !w_known;
  assign w_word = w_err ? NOP_INST : w_enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (w_accept) begin
      r_err <= w_err;
      if (w_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_err   = r_err;
  assign err_count = r_err_cnt;
`else
  assign w_word    = w_enc;
  assign out_err   = 1'b0;
  assign err_count = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_inst      <= '0;
      r_addr      <= BASE_ADDR;
      r_last      <= 1'b0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      // A same-cycle drain and accept simply reloads; valid stays high.
      r_out_valid <= 1'b1;
      r_inst      <= w_word;
      r_addr      <= w_word_addr;
      r_last      <= w_ptr_last;
      r_ptr       <= w_ptr_last ? '0 : r_ptr + PW'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_inst;
  assign out_addr  = r_addr;
  assign out_last  = r_last;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: random fields vs. a bit-arithmetic
// reference model, plus directed stall, wrap, reset and saturation cases.
module tb_inst_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, out_inst, out_addr;
  logic        out_last, out_err;
  logic [7:0]  err_count;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_last(out_last), .out_err(out_err),
    .err_count(err_count)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        last;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0, nfail = 0;
  int   m_ptr = 0, m_cnt = 0;
  int   rdy_mode = 0;  // 0 low, 1 high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each field is shifted into place by arithmetic on unsigned ints.
  function automatic void model(input int unsigned op, rd, rs1, rs2, f3, f7, imm,
                                output logic [31:0] inst, output logic err);
    int unsigned w;
    int          si;
    bit          re;
    si = int'(imm);
    re = 1'b0;
    case (op)
      'h33: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      'h13, 'h03, 'h67, 'h73:
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
          w  = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
          re = (imm >> 5) != 0;
        end else begin
          w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
          re = si < -2048 || si > 2047;
        end
      'h23: begin
        w  = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 31) << 7) | op;
        re = si < -2048 || si > 2047;
      end
      'h63: begin
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
             | (((imm >> 11) & 1) << 7) | op;
        re = si < -4096 || si > 4095 || (imm & 1) != 0;
      end
      'h37, 'h17: begin
        w  = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        re = (imm & 'hFFF) != 0;
      end
      'h6F: begin
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
        re = si < -(1 << 20) || si > (1 << 20) - 1 || (imm & 1) != 0;
      end
      default: begin
        w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        re = 1'b1;
      end
    endcase
    err  = CHK && re;
    inst = err ? NOP : w;
  endfunction

  task automatic send(input int unsigned op, rd, rs1, rs2, f3, f7, imm,
                      input bit use_c, input logic [31:0] cinst, input bit cerr);
    exp_t        e;
    logic [31:0] mi;
    logic        me;
    int          t;
    model(op, rd, rs1, rs2, f3, f7, imm, mi, me);
    if (use_c) begin mi = cinst; me = cerr; end
    in_valid = 1'b1; in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.inst = mi;
      e.addr = BASE + 32'(4 * m_ptr);
      e.last = (m_ptr == DEPTH - 1);
      e.err  = me;
      if (me && m_cnt < 255) m_cnt++;
      e.cnt  = 8'(m_cnt);
      m_ptr  = (m_ptr + 1) % DEPTH;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    sbq.delete(); m_ptr = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops on every output handshake, checks stall stability.
  logic        p_st;
  logic [31:0] p_inst, p_addr;
  logic        p_last, p_err;
  initial begin
    exp_t e;
    p_st = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_st = 1'b0;
      end else begin
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (p_st) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_inst", out_inst, p_inst);
          chk("stall_addr", out_addr, p_addr);
          chk("stall_last", 32'(out_last), 32'(p_last));
          chk("stall_err", 32'(out_err), 32'(p_err));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_word", out_inst, 32'hxxxx_xxxx);
          end else begin
            e = sbq.pop_front();
            chk("inst", out_inst, e.inst);
            chk("addr", out_addr, e.addr);
            chk("last", 32'(out_last), 32'(e.last));
            chk("err", 32'(out_err), 32'(e.err));
            chk("err_count", 32'(err_count), 32'(e.cnt));
          end
        end
        p_st = out_valid && !out_ready;
        p_inst = out_inst; p_addr = out_addr; p_last = out_last; p_err = out_err;
      end
    end
  end

  int unsigned ops[10] = '{'h33, 'h13, 'h03, 'h67, 'h73, 'h23, 'h63, 'h37, 'h17, 'h6F};
  int edges[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    'h000F_FFFE, 'h0010_0000, -'h0010_0000, -'h0010_0002, 31, 32,
                    'h1234_5000};

  initial begin
    int unsigned op, imm;
    int          t;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    rdy_mode = 1;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed encodings from known-good assembler output.
    send('h13, 1, 0, 0, 0, 0, 5, 1'b1, 32'h0050_0093, 1'b0);
    send('h23, 0, 1, 2, 2, 0, 8, 1'b1, 32'h0020_A423, 1'b0);
    send('h63, 0, 1, 2, 0, 0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3, 1'b0);
    send('h6F, 1, 0, 0, 0, 0, 'h800, 1'b1, 32'h0010_00EF, 1'b0);
    send('h13, 1, 0, 0, 0, 0, 2048, 1'b1, CHK ? NOP : 32'h8000_0093, CHK);
    idle();

    // Stall, then back-to-back across the address wrap.
    rdy_mode = 0;
    do_reset();
    send('h13, 1, 0, 0, 0, 0, 1, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1; in_imm = 32'd2;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    rdy_mode = 1;
    for (int i = 2; i <= 5; i++) send('h13, 1, 0, 0, 0, 0, i, 1'b0, 32'd0, 1'b0);
    idle(); idle();

    // Reset while a (possibly errored) word is stalled.
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send('h13, 2, 0, 0, 0, 0, 2048, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_cnt", 32'(err_count), CHK ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; sbq.delete(); m_ptr = 0; m_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_cnt", 32'(err_count), 32'd0);
    rdy_mode = 1;
    @(posedge clk); #1;
    send('h13, 3, 0, 0, 0, 0, 7, 1'b0, 32'd0, 1'b0);

    // Random fields under random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0:       imm = int'($urandom_range(0, 8191)) - 4096;
        1:       imm = $urandom;
        2:       imm = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        default: imm = edges[$urandom_range(0, 15)];
      endcase
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 127), imm, 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 4) == 0) idle();
    end

    // Unknown opcodes: error counter must saturate, not wrap.
    rdy_mode = 1;
    for (int n = 0; n < 260; n++) send('h7F, 1, 2, 3, 0, 0, n, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b0;

    t = 0;
    while (sbq.size() != 0 && t < 100) begin @(posedge clk); t++; end
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
